ift_sram_rr_arbiter: RTL

Round-robin arbiter that shares one single-port `ift_sram` bank between `NumReq` requesters (e.g. core data port, debug, DMA) and carries CellIFT taint alongside every control and data path. It sits directly in front of the bank: one requester wins per cycle, its request goes to the SRAM, and the 1-cycle read response returns with a per-requester valid. Arbitration decisions driven by tainted request lines are conservatively tainted, so timing-based leakage through contention is visible to the taint tracker.

---
 rtl/ift_sram_rr_arbiter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/ift_sram_rr_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM bank among NumReq requesters, with CellIFT taint.
// Latency: grant 0 cycles, response 1 cycle; losers are backpressured by withholding gnt_o and must hold their request.
module ift_sram_rr_arbiter #(
    parameter int NumReq    = 4,
    parameter int AddrWidth = 10,
    parameter int DataWidth = 32,
    parameter int ByteWidth = 8,
    parameter int NumTaints = 1,
    localparam int WidthBytes = (DataWidth + ByteWidth - 1) / ByteWidth,
    localparam int IdxW       = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic                                            clk_i,
    input  logic                                            rst_ni,
    input  logic [NumReq-1:0]                               req_i,
    input  logic [NumReq-1:0]                               we_i,
    input  logic [NumReq-1:0][AddrWidth-1:0]                addr_i,
    input  logic [NumReq-1:0][DataWidth-1:0]                wdata_i,
    input  logic [NumReq-1:0][WidthBytes-1:0]               be_i,
    output logic [NumReq-1:0]                               gnt_o,
    output logic [NumReq-1:0]                               rvalid_o,
    output logic [DataWidth-1:0]                            rdata_o,
    output logic                                            sram_req_o,
    output logic                                            sram_we_o,
    output logic [AddrWidth-1:0]                            sram_addr_o,
    output logic [DataWidth-1:0]                            sram_wdata_o,
    output logic [WidthBytes-1:0]                           sram_be_o,
    input  logic [DataWidth-1:0]                            sram_rdata_i,
    input  logic [NumTaints-1:0]                            clk_i_t0,
    input  logic [NumTaints-1:0]                            rst_ni_t0,
    input  logic [NumTaints-1:0][NumReq-1:0]                req_i_t0,
    input  logic [NumTaints-1:0][NumReq-1:0]                we_i_t0,
    input  logic [NumTaints-1:0][NumReq-1:0][AddrWidth-1:0] addr_i_t0,
    input  logic [NumTaints-1:0][NumReq-1:0][DataWidth-1:0] wdata_i_t0,
    input  logic [NumTaints-1:0][NumReq-1:0][WidthBytes-1:0] be_i_t0,
    output logic [NumTaints-1:0][NumReq-1:0]                gnt_o_t0,
    output logic [NumTaints-1:0][NumReq-1:0]                rvalid_o_t0,
    output logic [NumTaints-1:0][DataWidth-1:0]             rdata_o_t0,
    output logic [NumTaints-1:0]                            sram_req_o_t0,
    output logic [NumTaints-1:0]                            sram_we_o_t0,
    output logic [NumTaints-1:0][AddrWidth-1:0]             sram_addr_o_t0,
    output logic [NumTaints-1:0][DataWidth-1:0]             sram_wdata_o_t0,
    output logic [NumTaints-1:0][WidthBytes-1:0]            sram_be_o_t0,
    input  logic [NumTaints-1:0][DataWidth-1:0]             sram_rdata_i_t0
);

    if (NumTaints != 1) begin : g_bad_num_taints
        $error("ift_sram_rr_arbiter supports only NumTaints == 1");
    end

    logic [IdxW-1:0] rr_q, rr_d;
    logic [IdxW-1:0] rsp_idx_q, rsp_idx_d;
    logic            rsp_vld_q, rsp_vld_d;
    logic            ptr_t_q, ptr_t_d;
    logic            rsp_t_q, rsp_t_d;

    logic            win_vld;
    logic [IdxW-1:0] win_idx;
    int              cand;
    logic            dec_t;
    logic            unused_t0;

    assign unused_t0 = ^{clk_i_t0, rst_ni_t0};

    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = 0;
        for (int off = 0; off < NumReq; off++) begin
            cand = (int'(rr_q) + off) % NumReq;
            if (!win_vld && req_i[cand]) begin
                win_vld = 1'b1;
                win_idx = cand[IdxW-1:0];
            end
        end
    end

    always_comb begin
        gnt_o    = '0;
        rvalid_o = '0;
        for (int i = 0; i < NumReq; i++) begin
            gnt_o[i]    = win_vld && (int'(win_idx) == i);
            rvalid_o[i] = rsp_vld_q && (int'(rsp_idx_q) == i);
        end
    end

    // With no request win_idx is 0, so the bank sees requester 0's fields.
    assign sram_req_o   = |req_i;
    assign sram_we_o    = we_i[win_idx];
    assign sram_addr_o  = addr_i[win_idx];
    assign sram_wdata_o = wdata_i[win_idx];
    assign sram_be_o    = be_i[win_idx];
    assign rdata_o      = sram_rdata_i;

    // A tainted request line or tainted pointer makes the whole decision tainted.
    assign dec_t = (|(req_i_t0[0] & (req_i | req_i_t0[0]))) | ptr_t_q;

    assign gnt_o_t0[0]        = {NumReq{dec_t}};
    assign sram_req_o_t0[0]   = dec_t;
    assign sram_we_o_t0[0]    = dec_t ? 1'b1 : we_i_t0[0][win_idx];
    assign sram_addr_o_t0[0]  = dec_t ? {AddrWidth{1'b1}} : addr_i_t0[0][win_idx];
    assign sram_wdata_o_t0[0] = dec_t ? {DataWidth{1'b1}} : wdata_i_t0[0][win_idx];
    assign sram_be_o_t0[0]    = dec_t ? {WidthBytes{1'b1}} : be_i_t0[0][win_idx];
    assign rvalid_o_t0[0]     = {NumReq{rsp_t_q}};
    assign rdata_o_t0[0]      = sram_rdata_i_t0[0] | {DataWidth{rsp_t_q}};

    always_comb begin
        rr_d      = rr_q;
        rsp_idx_d = rsp_idx_q;
        rsp_vld_d = win_vld;
        rsp_t_d   = dec_t;
        ptr_t_d   = ptr_t_q;
        if (win_vld) begin
            rr_d      = (int'(win_idx) == NumReq - 1) ? '0 : win_idx + 1'b1;
            rsp_idx_d = win_idx;
        end
        // The pointer could have moved if any request line might be set.
        if (|(req_i | req_i_t0[0])) begin
            ptr_t_d = dec_t;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q      <= '0;
            rsp_idx_q <= '0;
            rsp_vld_q <= 1'b0;
            ptr_t_q   <= 1'b0;
            rsp_t_q   <= 1'b0;
        end else begin
            rr_q      <= rr_d;
            rsp_idx_q <= rsp_idx_d;
            rsp_vld_q <= rsp_vld_d;
            ptr_t_q   <= ptr_t_d;
            rsp_t_q   <= rsp_t_d;
        end
    end

endmodule
